// File: rtl/qsqrt_iter_pkg.sv
// Shared definitions for the qsqrt_iter family: FSM state encoding and derived sizing macros.
// QSQRT_RW rounds WIDTH-1+FRAC up to even; QSQRT_ITER is the number of root bits produced.
`ifndef QSQRT_DEFS_VH
`define QSQRT_DEFS_VH
`define QSQRT_RW(w, f)   (((((w) - 1 + (f)) + 1) / 2) * 2)
`define QSQRT_ITER(w, f) (`QSQRT_RW(w, f) / 2)
`endif

package qsqrt_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/qsqrt_step.sv
// One radix-2 digit-recurrence stage: consumes two radicand bits, yields one root bit.
// Purely combinational so it can be reused in an unrolled or pipelined root.
module qsqrt_step #(
  parameter int ROOTW = 23
) (
  input  logic [ROOTW+1:0] rem_i,
  input  logic [ROOTW-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [ROOTW+1:0] rem_o,
  output logic             root_bit_o
);

  logic [ROOTW+3:0] shifted;
  logic [ROOTW+4:0] trial;

  assign shifted = {rem_i, bits_i};
  // One spare MSB keeps the subtraction sign visible without overflow.
  assign trial   = {1'b0, shifted} - (ROOTW+5)'({root_i, 2'b01});

  assign root_bit_o = ~trial[ROOTW+4];
  assign rem_o      = root_bit_o ? (ROOTW+2)'(trial) : (ROOTW+2)'(shifted);

endmodule

// File: rtl/qsqrt_iter.sv
// qsqrt_iter: signed Q-format square root, radix-2 digit recurrence, one root bit per clock.
// Define QSQRT_ROUND_EN for round-to-nearest; the default build truncates (floor).
module qsqrt_iter
  import qsqrt_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int RW   = `QSQRT_RW(WIDTH, FRAC);
  localparam int ITER = `QSQRT_ITER(WIDTH, FRAC);
  localparam int REMW = ITER + 2;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if (ITER + 1 > WIDTH - 1) begin : g_bad_params
      $error("qsqrt_iter: rounded root (ITER+1 bits) does not fit in WIDTH-1 bits");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [RW-1:0]    rad_q, rad_d;
  logic [REMW-1:0]  rem_q, rem_d;
  logic [ITER-1:0]  root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic [RW-1:0]    rad_load;
  logic [REMW-1:0]  step_rem;
  logic             step_bit;
  logic [ITER-1:0]  root_next;
  logic [WIDTH-1:0] result;

  // Magnitude scaled by 2^FRAC so the root keeps FRAC fractional bits.
  always_comb begin
    rad_load = '0;
    rad_load[WIDTH-2+FRAC:FRAC] = in_data[WIDTH-2:0];
  end

  qsqrt_step #(
    .ROOTW(ITER)
  ) u_step (
    .rem_i      (rem_q),
    .root_i     (root_q),
    .bits_i     (rad_q[RW-1 -: 2]),
    .rem_o      (step_rem),
    .root_bit_o (step_bit)
  );

  assign root_next = {root_q[ITER-2:0], step_bit};

`ifdef QSQRT_ROUND_EN
  logic            round_up;
  logic [ITER:0]   root_rnd;
  // Remainder above the root means the exact root lies past q+0.5.
  assign round_up = step_rem > REMW'(root_next);
  assign root_rnd = {1'b0, root_next} + {{ITER{1'b0}}, round_up};
  assign result   = WIDTH'(root_rnd);
`else
  assign result   = WIDTH'(root_next);
`endif

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data[WIDTH-1]) begin
            state_d     = DONE;
            out_err_d   = 1'b1;
            out_data_d  = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d   = CALC;
            rad_d     = rad_load;
            rem_d     = '0;
            root_d    = '0;
            cnt_d     = '0;
            out_err_d = 1'b0;
          end
        end
      end

      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = root_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_qsqrt_iter.sv
// Scoreboard bench for qsqrt_iter: expected {err,data} pushed at accept, popped at out_valid.
`timescale 1ns/1ps
module tb_qsqrt_iter;

  localparam int WIDTH = 32;
  localparam int FRAC  = 15;
  localparam int ITER  = 23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  logic [32:0] sb[$];

  qsqrt_iter #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: largest q with q*q <= N by binary search, optional round-to-nearest.
  function automatic logic [32:0] model(input logic [31:0] d);
    longint unsigned n, lo, hi, mid, q;
    if (d[31]) return {1'b1, 32'h0};
    n  = 64'(d[30:0]) << FRAC;
    lo = 0;
    hi = 64'd1 << 23;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
    q = lo;
`ifdef QSQRT_ROUND_EN
    if (n - q * q > q) q = q + 1;
`endif
    return {1'b0, q[31:0]};
  endfunction

  task automatic note_accept(input logic [32:0] exp);
    acc_cyc = cyc;
    sb.push_back(exp);
  endtask

  task automatic drive_op(input logic [31:0] d, input logic [32:0] exp);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    note_accept(exp);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic await_result(input int exp_lat, input int hold);
    int          guard;
    logic [32:0] exp;
    logic [32:0] got;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 33'h0;
    if (!out_valid) begin
      check_eq("valid_timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    check_eq("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
    got = {out_err, out_data};
    check_eq("result", 64'(got), 64'(exp));
    n_txn++;
    $display("txn %0d: err=%0b data=0x%08h exp_err=%0b exp_data=0x%08h lat=%0d",
             n_txn, out_err, out_data, exp[32], exp[31:0], cyc - acc_cyc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_out", 64'({out_valid, out_err, out_data}), 64'({1'b1, exp}));
      check_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("drain_valid", {63'd0, out_valid}, 64'd0);
    check_eq("drain_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [32:0] e;
    logic        saw;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_err", {63'd0, out_err}, 64'd0);
    rst_n = 1'b1;

    drive_op(32'h0002_0000, {1'b0, 32'h0001_0000});
    await_result(ITER, 0);
`ifdef QSQRT_ROUND_EN
    drive_op(32'h0001_0000, {1'b0, 32'h0000_B505});
    await_result(ITER, 0);
    drive_op(32'h7FFF_FFFF, {1'b0, 32'h0080_0000});
    await_result(ITER, 0);
`else
    drive_op(32'h0001_0000, {1'b0, 32'h0000_B504});
    await_result(ITER, 0);
    drive_op(32'h7FFF_FFFF, {1'b0, 32'h007F_FFFF});
    await_result(ITER, 0);
`endif
    drive_op(32'h0000_0000, {1'b0, 32'h0});
    await_result(ITER, 0);
    drive_op(32'hFFFF_8000, {1'b1, 32'h0});
    await_result(0, 0);

    // Backpressure: second operand offered throughout, accepted only after the drain.
    drive_op(32'h0009_0000, model(32'h0009_0000));
    in_valid = 1'b1;
    in_data  = 32'h0004_8000;
    await_result(ITER, 10);
    @(posedge clk);
    @(negedge clk);
    note_accept({1'b0, 32'h0001_8000});
    in_valid = 1'b0;
    await_result(ITER, 0);

    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      if (i % 4 != 3) d[31] = 1'b0;
      if (i == 0) d = 32'h0000_0001;
      e = model(d);
      drive_op(d, e);
      await_result(e[32] ? 0 : ITER, 0);
    end

    // Reset at CALC cycle 10 must abort with no output afterwards.
    drive_op(32'h1234_5678, model(32'h1234_5678));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check_eq("no_stale", {63'd0, saw}, 64'd0);
    drive_op(32'h0004_8000, {1'b0, 32'h0001_8000});
    await_result(ITER, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
